// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data memory sequencer.
// FSM encoding, RV32I load/store FUNC3 codes and default timeout.
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/load_store_align.sv
// Combinational access decode: legality, byte enables, store lane
// replication and load byte/halfword extraction with extension.
module load_store_align
  import data_mem_ctrl_pkg::*;
(
  input  logic        is_write,
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    legal     = 1'b0;
    be        = 4'b1111;
    wdata_rep = wdata;
    case (func3)
      F3_B: begin
        legal = 1'b1;
        if (is_write) begin
          be        = 4'b0001 << offset;
          wdata_rep = {4{wdata[7:0]}};
        end
      end
      F3_H: begin
        legal = !offset[0];
        if (is_write) begin
          be        = 4'b0011 << offset;
          wdata_rep = {2{wdata[15:0]}};
        end
      end
      F3_W: begin
        legal = (offset == 2'b00);
      end
      F3_BU, F3_HU: begin
        // unsigned forms exist only for loads
        legal = !is_write && !((func3 == F3_HU) && offset[0]);
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  assign shifted = rdata >> {ld_offset, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    case (ld_func3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    ld_data = rdata;
      F3_BU:   ld_data = {24'h0, shifted[7:0]};
      F3_HU:   ld_data = {16'h0, shifted[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage sequencer for a handshaked data memory: latches the access,
// holds a level request until ack or timeout, stalls the pipeline meanwhile.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic        STALL,
  output logic [31:0] READ_DATA,
  output logic        MISALIGNED,
  output logic        BUS_ERR,
  output logic        DM_REQ,
  output logic        DM_WE,
  output logic [31:0] DM_ADDR,
  output logic [3:0]  DM_BE,
  output logic [31:0] DM_WDATA,
  input  logic [31:0] DM_RDATA,
  input  logic        DM_ACK
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        berr_q, berr_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        access;
  logic        legal;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] ld_data;

  assign access = MEM_READ | MEM_WRITE;

  load_store_align u_align (
    .is_write  (MEM_WRITE),
    .func3     (FUNC3),
    .offset    (ADDRESS[1:0]),
    .wdata     (WRITE_DATA),
    .ld_func3  (f3_q),
    .ld_offset (off_q),
    .rdata     (DM_RDATA),
    .legal     (legal),
    .be        (be_n),
    .wdata_rep (wdata_n),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    berr_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (access && legal) begin
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = MEM_WRITE;
          addr_d  = {ADDRESS[31:2], 2'b00};
          be_d    = be_n;
          wdata_d = wdata_n;
          f3_d    = FUNC3;
          off_d   = ADDRESS[1:0];
          cnt_d   = 8'd0;
        end
      end
      WAIT: begin
        if (DM_ACK) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) rdata_d = ld_data;
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = 32'h0;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      f3_q    <= 3'h0;
      off_q   <= 2'h0;
      rdata_q <= 32'h0;
      berr_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign STALL = RST & (((state_q == IDLE) & access & legal) |
                        (state_q == WAIT));
  assign MISALIGNED = RST & (state_q == IDLE) & access & !legal;

  assign DM_REQ    = req_q;
  assign DM_WE     = we_q;
  assign DM_ADDR   = addr_q;
  assign DM_BE     = be_q;
  assign DM_WDATA  = wdata_q;
  assign READ_DATA = rdata_q;
  assign BUS_ERR   = berr_q;

endmodule
